elbeth_dmem_interface: RTL
==========================

// Module: elbeth_dmem_interface
// PURPOSE
//  MEM-stage responder for the data-memory handshake. Accepts one load/store per instruction,
//  raises dmem_request_stall until the access completes, and steers store byte lanes.
//  Extracts and sign/zero-extends load data, and flags misaligned accesses and bus timeouts.
//  Sits between the pipeline MEM stage and the dual-port data RAM/bus.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in REQ without dmem_ready before bus error (>=1)
//  TO_WIDTH        8    timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk                 in   1   clock, rising edge
//  rst                 in   1   synchronous reset, ACTIVE-LOW
//  mem_en              in   1   access requested by instruction in MEM stage
//  mem_wr              in   1   1=store, 0=load
//  mem_size            in   2   00 byte, 01 halfword, 10 word, 11 illegal
//  mem_sign            in   1   load: 1 sign-extend, 0 zero-extend
//  mem_address         in   32  byte address
//  mem_data_w          in   32  store data (LSB-aligned)
//  mem_data_r          out  32  extended load data; valid in DONE cycle
//  dmem_request_stall  out  1   stall PC/IF/ID/EX while access outstanding
//  mem_misaligned      out  1   misaligned or illegal-size access (combinational)
//  bus_error           out  1   one-cycle pulse on timeout
//  dmem_valid          out  1   request valid to memory (registered)
//  dmem_we             out  1   write enable to memory
//  dmem_wbe            out  4   byte write enables
//  dmem_addr           out  32  word address {addr[31:2],2'b00}
//  dmem_wdata          out  32  lane-replicated store data
//  dmem_rdata          in   32  read data
//  dmem_ready          in   1   memory accepts/completes request this cycle
// BEHAVIOUR
//  Reset (rst==0 at edge): state IDLE, counter 0, all registered outputs 0.
//  Reset mid-access: abort; dmem_valid 0 next cycle; a late dmem_ready is ignored in IDLE.
//  Misaligned: mem_size==11, half with addr[0]==1, word with addr[1:0]!=0.
//  Misaligned: mem_misaligned=1 while mem_en; no request issued, no stall, store suppressed.
//  FSM IDLE->REQ->DONE->IDLE; IDLE->REQ->ERR->IDLE.
//   IDLE: mem_en & aligned -> capture addr/data/size/sign/wr, load counter 0, go REQ.
//   IDLE: dmem_request_stall=1 combinationally in that cycle; dmem_ready ignored.
//   REQ: dmem_valid=1; outputs held stable until dmem_ready; counter increments.
//   REQ: dmem_ready -> latch formatted load data (0 for stores) into mem_data_r, go DONE.
//   REQ: no ready and counter==TIMEOUT_CYCLES-1 -> go ERR. dmem_ready wins if coincident.
//   DONE: valid=0, stall=0; pipeline captures mem_data_r; mem_en this cycle ignored -> IDLE.
//   ERR: valid=0, stall=0, bus_error=1, mem_data_r=0 -> IDLE.
//  dmem_request_stall = (IDLE & mem_en & aligned) | REQ.
//  Min latency 2 stalled cycles (IDLE, REQ with ready) plus DONE.
//  Store lanes: byte wdata={4{d[7:0]}}, wbe=4'b0001<<addr[1:0].
//  Store lanes: half wdata={2{d[15:0]}}, wbe=addr[1]?1100:0011; word wbe=1111. Load wbe=0000.
//  Load extract: lane=rdata>>(8*addr[1:0]); byte lane[7:0], half lane[15:0], word whole.
//  Load extend: sign-extend if mem_sign else zero-extend.
// TESTING
//  Load byte signed, addr 0x1003, rdata 0x80112233, ready in 1st REQ -> mem_data_r 0xFFFFFF80.
//  Above case: stall high exactly 2 cycles.
//  Store half 0xABCD @0x2002 -> dmem_wdata 0xABCDABCD, wbe 1100, we=1, addr 0x2000.
//  Load word @0x3001 -> mem_misaligned=1, dmem_valid never asserts, stall stays 0.
//  Ready withheld TIMEOUT_CYCLES=4 -> ERR, bus_error 1-cycle pulse, stall drops, data_r=0.
//  rst=0 during REQ, then dmem_ready=1 after reset -> state IDLE, no DONE, valid stays 0.
//  Back-to-back loads, ready delayed 3 cycles each -> each completes once; no dup requests.

Source files
------------

// File: rtl/elbeth_dmem_interface.sv
// elbeth_dmem_interface
//   MEM-stage responder for the data-memory handshake. One load/store per
//   instruction: the request is captured in IDLE, presented to memory in REQ
//   until dmem_ready, and completes in DONE (or ERR on bus timeout). Store
//   data is lane-replicated with byte enables; load data is extracted from the
//   addressed lane and sign/zero-extended.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-low reset
//   mem_en/mem_wr       access request / 1=store 0=load
//   mem_size/mem_sign   00 byte 01 half 10 word 11 illegal / load sign-extend
//   mem_address         byte address
//   mem_data_w          LSB-aligned store data
//   mem_data_r          extended load data, valid in the DONE cycle
//   dmem_request_stall  holds the front of the pipeline while access is open
//   mem_misaligned      combinational misaligned/illegal-size flag
//   bus_error           one-cycle pulse on timeout
//   dmem_valid/we/wbe/addr/wdata  registered request to memory
//   dmem_rdata/dmem_ready         memory response
module elbeth_dmem_interface #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic        mem_sign,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_data_w,
  output logic [31:0] mem_data_r,
  output logic        dmem_request_stall,
  output logic        mem_misaligned,
  output logic        bus_error,
  output logic        dmem_valid,
  output logic        dmem_we,
  output logic [3:0]  dmem_wbe,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t              state, state_next;
  logic [TO_WIDTH-1:0] cnt;
  logic [1:0]          size_p0;
  logic                sign_p0;
  logic [1:0]          lane_p0;
  logic                misaligned;
  logic                accept;
  logic                timeout_hit;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = lo[0];
      2'b10:   is_misaligned = (lo != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_wbe(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   store_wbe = 4'b0001 << lo;
      2'b01:   store_wbe = lo[1] ? 4'b1100 : 4'b0011;
      default: store_wbe = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   store_wdata = {4{d[7:0]}};
      2'b01:   store_wdata = {2{d[15:0]}};
      default: store_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] load_format(input logic [1:0] size, input logic sign,
                                              input logic [1:0] lo, input logic [31:0] rdata);
    logic [31:0] lane;
    lane = rdata >> {lo, 3'b000};
    case (size)
      2'b00:   load_format = sign ? {{24{lane[7]}}, lane[7:0]} : {24'b0, lane[7:0]};
      2'b01:   load_format = sign ? {{16{lane[15]}}, lane[15:0]} : {16'b0, lane[15:0]};
      default: load_format = lane;
    endcase
  endfunction

  assign misaligned         = is_misaligned(mem_size, mem_address[1:0]);
  assign accept             = (state == IDLE) && mem_en && !misaligned;
  assign mem_misaligned     = mem_en && misaligned;
  assign dmem_request_stall = accept || (state == REQ);
  assign timeout_hit        = (cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = REQ;
      // dmem_ready takes priority over a coincident timeout
      REQ:     if (dmem_ready) state_next = DONE;
               else if (timeout_hit) state_next = ERR;
      default: state_next = IDLE;
    endcase
  end

  // p0: request capture and memory handshake
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      dmem_valid <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_wbe   <= 4'b0;
      dmem_addr  <= 32'b0;
      dmem_wdata <= 32'b0;
      mem_data_r <= 32'b0;
      bus_error  <= 1'b0;
    end else begin
      state     <= state_next;
      bus_error <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt        <= '0;
            dmem_valid <= 1'b1;
            dmem_we    <= mem_wr;
            dmem_wbe   <= mem_wr ? store_wbe(mem_size, mem_address[1:0]) : 4'b0;
            dmem_addr  <= {mem_address[31:2], 2'b00};
            dmem_wdata <= mem_wr ? store_wdata(mem_size, mem_data_w) : 32'b0;
          end
        end
        REQ: begin
          if (dmem_ready) begin
            dmem_valid <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wbe   <= 4'b0;
            mem_data_r <= dmem_we ? 32'b0 : load_format(size_p0, sign_p0, lane_p0, dmem_rdata);
          end else if (timeout_hit) begin
            dmem_valid <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wbe   <= 4'b0;
            mem_data_r <= 32'b0;
            bus_error  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Load formatting attributes; only meaningful while an access is open
  always_ff @(posedge clk) begin
    if (accept) begin
      size_p0 <= mem_size;
      sign_p0 <= mem_sign;
      lane_p0 <= mem_address[1:0];
    end
  end

endmodule
